score_keeper: RTL
=================

Name: score_keeper

Overview:
- Game-side score accumulator that sits directly upstream of the two-digit seven-segment score decoder.
- Counts enemy-hit events during play and saturates at the two-digit display limit.
- Runs a small game state machine (idle / play / over) and holds a session high score.
- Drives the 32-bit score bus consumed by the decoder; high_score can be muxed onto the same decoder.

Parameters:
- HIT_POINTS, 1, points added per hit (multiplied by combo level when COMBO_EN is defined)
- MAX_SCORE, 99, saturation ceiling; must not exceed 99 (decoder range)
- COMBO_WINDOW, 16, cycles after a hit during which the next hit extends the combo (COMBO_EN only)

Ports:
- clk  input  1  system clock
- rst_n  input  1  synchronous active-low reset
- start  input  1  one-cycle pulse: begin or restart a game
- game_over  input  1  one-cycle pulse: player destroyed
- hit  input  1  one-cycle pulse per enemy destroyed
- score  output  32  current score, to the seven-segment decoder
- high_score  output  32  best score since reset
- playing  output  1  high while in PLAY
- max_reached  output  1  high when score == MAX_SCORE
- new_record  output  1  high in OVER if the finished game set a new high score
- combo  output  2  current combo level (0..3)

Behaviour:
- Clock and reset: one clock, clk. Reset is rst_n, synchronous and active-low, sampled on the rising edge of clk.
- Reset values: state IDLE, score 0, high_score 0, playing 0, new_record 0, combo 0, window timer 0. This applies mid-game too; high_score is cleared only by reset.
- All outputs are registered or decoded from registers. score reflects a hit one cycle after the hit edge.
- States:
  - IDLE: hit and game_over ignored. start -> PLAY.
  - PLAY: start -> PLAY (restart). game_over -> OVER.
  - OVER: hit and game_over ignored. start -> PLAY.
- Any accepted start, in any state, on the same edge: score <= 0, combo <= 0, timer <= 0, new_record <= 0.
- Priority in PLAY: game_over beats start and hit. A hit coincident with game_over is discarded. start beats hit.
- Entering OVER:
  - if score > high_score: high_score <= score and new_record <= 1;
  - otherwise both are unchanged.
  - A tie is not a record.
- Add rule: score <= min(score + add, MAX_SCORE). Compute with a 33-bit intermediate so there is no wrap. Once saturated, further hits leave score at MAX_SCORE.
- add = HIT_POINTS when COMBO_EN is undefined.
- max_reached = (score == MAX_SCORE). playing = (state == PLAY).
- Multiple hits cannot arrive per cycle; hit held high counts once per cycle.

Optional Feature:
- Macro: SCORE_COMBO_EN.
- Defined, on an accepted hit in PLAY:
  - combo_next = (timer != 0) ? min(combo+1, 3) : 0;
  - add = HIT_POINTS * (combo_next + 1);
  - combo <= combo_next; timer <= COMBO_WINDOW.
- Defined, on a non-hit cycle: a nonzero timer decrements; when it reaches 0, combo <= 0 on that same edge.
- Defined, timer width: $clog2(COMBO_WINDOW+1).
- Undefined: no timer logic; combo output tied to 0; add = HIT_POINTS.

Test Plan:
1. rst_n low 2 cycles, then high -> score 0, high_score 0, playing 0, combo 0; hits pulsed in IDLE leave score 0.
2. start, then 5 single-cycle hits -> score 5 one cycle after last hit, playing 1, max_reached 0.
3. start, then 120 hits -> score 99, max_reached 1; score stays 99 with no wrap.
4. Game with 5 hits, then game_over -> high_score 5, new_record 1. start, 3 hits, game_over -> high_score 5, new_record 0, score 3. Hits in OVER are ignored.
5. In PLAY with score 7, hit and game_over on the same cycle -> score 7, state OVER. rst_n low mid-PLAY -> all outputs 0 next edge, including high_score.
6. SCORE_COMBO_EN, COMBO_WINDOW=4, after start:
   - hits at cycles 0, 2, 4, 6 -> adds 1, 2, 3, 4 -> score 10, combo 3;
   - no hits cycles 7-11 -> combo 0 by cycle 10;
   - hit at cycle 12 -> score 11.

Source files
------------

// File: rtl/score_keeper.sv
// Score accumulator with idle/play/over game FSM, saturating score and session high score.
// Optional combo multiplier enabled by defining SCORE_COMBO_EN.
module score_keeper #(
  parameter int unsigned HIT_POINTS   = 1,
  parameter int unsigned MAX_SCORE    = 99,
  parameter int unsigned COMBO_WINDOW = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        game_over,
  input  logic        hit,
  output logic [31:0] score,
  output logic [31:0] high_score,
  output logic        playing,
  output logic        max_reached,
  output logic        new_record,
  output logic [1:0]  combo
);

  typedef enum logic [1:0] {IDLE, PLAY, OVER} state_t;

  state_t      state, state_next;
  logic [31:0] score_next, high_next;
  logic        record_next;
  logic        start_ok, over_ok, hit_ok;
  logic [31:0] add;
  logic [32:0] sum;
  logic [31:0] sat_score;

  // game_over wins over start in PLAY; start wins over hit.
  assign over_ok  = (state == PLAY) && game_over;
  assign start_ok = start && !over_ok;
  assign hit_ok   = (state == PLAY) && hit && !game_over && !start;

`ifdef SCORE_COMBO_EN
  localparam int unsigned TW = $clog2(COMBO_WINDOW + 1);

  logic [TW-1:0] timer, timer_next;
  logic [1:0]    combo_q, combo_next, level;

  always_comb begin
    level = '0;
    if (timer != '0)
      level = (combo_q == 2'd3) ? 2'd3 : combo_q + 2'd1;
  end

  assign add   = 32'(HIT_POINTS) * (32'(level) + 32'd1);
  assign combo = combo_q;

  always_comb begin
    timer_next = timer;
    combo_next = combo_q;
    if (start_ok) begin
      timer_next = '0;
      combo_next = '0;
    end else if (hit_ok) begin
      timer_next = TW'(COMBO_WINDOW);
      combo_next = level;
    end else if (timer != '0) begin
      timer_next = timer - 1'b1;
      if (timer == TW'(1))
        combo_next = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      timer   <= '0;
      combo_q <= '0;
    end else begin
      timer   <= timer_next;
      combo_q <= combo_next;
    end
  end
`else
  assign add   = 32'(HIT_POINTS);
  assign combo = '0;
`endif

  // 33-bit sum so saturation is checked before any wrap.
  assign sum       = {1'b0, score} + {1'b0, add};
  assign sat_score = (sum > 33'(MAX_SCORE)) ? 32'(MAX_SCORE) : sum[31:0];

  always_comb begin
    state_next  = state;
    score_next  = score;
    high_next   = high_score;
    record_next = new_record;
    if (over_ok) begin
      state_next = OVER;
      if (score > high_score) begin
        high_next   = score;
        record_next = 1'b1;
      end
    end else if (start_ok) begin
      state_next  = PLAY;
      score_next  = '0;
      record_next = 1'b0;
    end else if (hit_ok) begin
      score_next = sat_score;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      score      <= '0;
      high_score <= '0;
      new_record <= 1'b0;
    end else begin
      state      <= state_next;
      score      <= score_next;
      high_score <= high_next;
      new_record <= record_next;
    end
  end

  assign playing     = (state == PLAY);
  assign max_reached = (score == 32'(MAX_SCORE));

endmodule
